// File: rtl/rv_pkg.sv
// Shared types for the ready/valid register scheduler: read and write FSM
// state encodings plus a small index helper used by the round-robin pointer.
package rv_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_OFFER = 2'd2
  } read_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } write_state_t;

  // Next index after idx, wrapping back to 0 at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: returns the lowest requesting index at or after the
// pointer, wrapping from NUM_REGS-1 back to 0, and whether anyone requested.
module rr_arbiter #(
  parameter int NUM_REGS = 4,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0] req_i,
  input  logic [AW-1:0]       ptr_i,
  output logic [AW-1:0]       grant_o,
  output logic                any_o
);

  logic [AW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      idx = AW'((int'(ptr_i) + i) % NUM_REGS);
      if (req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv_reg_scheduler.sv
// Scheduler between a bank of ready/valid device registers and a host.
// A read FSM forwards pending register changes to the host one word at a
// time in round-robin order; an independent write FSM routes host write
// commands to a single register and acknowledges them with a one-cycle pulse.
module rv_reg_scheduler
  import rv_pkg::*;
#(
  parameter  int NUM_REGS   = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  output logic [NUM_REGS-1:0]            reg_read_enable_o,
  output logic [NUM_REGS-1:0]            reg_read_ready_o,
  input  logic [NUM_REGS-1:0]            reg_read_valid_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_read_data_i,
  output logic [NUM_REGS-1:0]            reg_write_enable_o,
  output logic [NUM_REGS-1:0]            reg_write_valid_o,
  input  logic [NUM_REGS-1:0]            reg_write_ready_i,
  output logic [DATA_WIDTH-1:0]          reg_write_data_o,
  output logic                           host_read_valid_o,
  input  logic                           host_read_ready_i,
  output logic [AW-1:0]                  host_read_addr_o,
  output logic [DATA_WIDTH-1:0]          host_read_data_o,
  input  logic                           host_write_valid_i,
  output logic                           host_write_ready_o,
  input  logic [AW-1:0]                  host_write_addr_i,
  input  logic [DATA_WIDTH-1:0]          host_write_data_i
);

  read_state_t           rd_state, rd_next;
  logic [AW-1:0]         rr_ptr;
  logic [AW-1:0]         grant_q;
  logic [AW-1:0]         arb_grant;
  logic                  arb_any;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic [DATA_WIDTH-1:0] rdata_q;

  write_state_t          wr_state, wr_next;
  logic [AW-1:0]         waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  addr_ok;
  logic                  wr_done;

  // Read enables follow reset directly: low in reset, all-ones otherwise.
  assign reg_read_enable_o = {NUM_REGS{rst_ni}};

  rr_arbiter #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_rr_arbiter (
    .req_i   (reg_read_valid_i),
    .ptr_i   (rr_ptr),
    .grant_o (arb_grant),
    .any_o   (arb_any)
  );

  // ---------------------------------------------------------------- read side

  // Read FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_state <= R_IDLE;
    else         rd_state <= rd_next;
  end

  // Read FSM next state: grant, fetch for one cycle, then hold the offer.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (arb_any) rd_next = R_FETCH;
      R_FETCH: rd_next = R_OFFER;
      R_OFFER: if (host_read_ready_i) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Select the granted register's data word out of the flattened bus.
  always_comb begin
    fetch_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (grant_q == AW'(i)) fetch_data = reg_read_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read datapath: latch grant, capture data while fetching, advance pointer on handoff.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      rdata_q <= '0;
    end else begin
      if (rd_state == R_IDLE && arb_any) grant_q <= arb_grant;
      if (rd_state == R_FETCH) rdata_q <= fetch_data;
      if (rd_state == R_OFFER && host_read_ready_i) rr_ptr <= AW'(wrap_inc(int'(grant_q), NUM_REGS));
    end
  end

  // Read outputs come from state and registers only, never from host ready.
  always_comb begin
    reg_read_ready_o  = '0;
    host_read_valid_o = 1'b0;
    host_read_addr_o  = '0;
    host_read_data_o  = '0;
    case (rd_state)
      R_FETCH: reg_read_ready_o[grant_q] = 1'b1;
      R_OFFER: begin
        host_read_valid_o = 1'b1;
        host_read_addr_o  = grant_q;
        host_read_data_o  = rdata_q;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------- write side

  // Out-of-range targets can only occur for non-power-of-two banks; they
  // complete immediately without touching any register.
  assign addr_ok = (int'(waddr_q) < NUM_REGS);
  assign wr_done = addr_ok ? reg_write_ready_i[waddr_q] : 1'b1;

  // Write FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wr_state <= W_IDLE;
    else         wr_state <= wr_next;
  end

  // Write FSM next state: accept a command, stay busy until the target is ready.
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (host_write_valid_i) wr_next = W_BUSY;
      W_BUSY:  if (wr_done) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // Capture the host command when it is accepted from idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (wr_state == W_IDLE && host_write_valid_i) begin
      waddr_q <= host_write_addr_i;
      wdata_q <= host_write_data_i;
    end
  end

  // Strobe only the latched target while busy; acknowledge in the completing cycle.
  always_comb begin
    reg_write_enable_o = '0;
    reg_write_valid_o  = '0;
    reg_write_data_o   = '0;
    host_write_ready_o = 1'b0;
    if (wr_state == W_BUSY) begin
      reg_write_data_o   = wdata_q;
      host_write_ready_o = wr_done;
      if (addr_ok) begin
        reg_write_enable_o[waddr_q] = 1'b1;
        reg_write_valid_o[waddr_q]  = 1'b1;
      end
    end
  end

endmodule
